// File: rtl/game_tick_pkg.sv
// Shared types and constants for the game tick receiver.
package game_tick_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int unsigned MAX_PENDING = 3;

endpackage : game_tick_pkg

// File: rtl/pulse_edge_sync.sv
// Three-flop synchronizer that flags every transition of an asynchronous input.
module pulse_edge_sync (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic edge_o
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Both edges count; s2/s3 are already metastability-clean.
   assign edge_o = s2 ^ s3;

endmodule : pulse_edge_sync

// File: rtl/game_tick_receiver.sv
// Turns timebase transitions into divided game steps, queued and offered over req/ack.
module game_tick_receiver
   import game_tick_pkg::*;
#(
   parameter int unsigned TICK_W = 16,
   parameter int unsigned DIV_W  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              pulse_in,
   input  logic [DIV_W-1:0]  divide,
   input  logic              step_ack,
   output logic              step_req,
   output logic [TICK_W-1:0] tick_count,
   output logic [1:0]        pending,
   output logic              overrun
);

   logic             tick;
   logic             step_gen;
   logic             step_take;
   logic [DIV_W-1:0] div_cnt;
   state_t           state;

   pulse_edge_sync u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (pulse_in),
      .edge_o (tick)
   );

   // A step is produced on a tick that completes the divide period; one is consumed leaving IDLE.
   always_comb begin
      step_gen  = 1'b0;
      step_take = 1'b0;
      if (enable) begin
         step_gen  = tick && (div_cnt >= divide);
         step_take = (state == IDLE) && (pending != 2'd0);
      end
   end

   // Tick counter and divider.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_count <= '0;
         div_cnt    <= '0;
      end else if (!enable) begin
         tick_count <= '0;
         div_cnt    <= '0;
      end else if (tick) begin
         tick_count <= tick_count + TICK_W'(1);
         if (div_cnt >= divide) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Saturating step queue; overrun is sticky until resetn and survives enable low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending <= 2'd0;
         overrun <= 1'b0;
      end else if (!enable) begin
         pending <= 2'd0;
      end else begin
         unique case ({step_gen, step_take})
            2'b10: begin
               if (pending == 2'(MAX_PENDING)) begin
                  overrun <= 1'b1;
               end else begin
                  pending <= pending + 2'd1;
               end
            end
            2'b01:   pending <= pending - 2'd1;
            default: ;
         endcase
      end
   end

   // Handshake FSM; GAP enforces two low cycles between consecutive requests.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         step_req <= 1'b0;
      end else if (!enable) begin
         state    <= IDLE;
         step_req <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pending != 2'd0) begin
                  state    <= REQ;
                  step_req <= 1'b1;
               end
            end
            REQ: begin
               if (step_ack) begin
                  state    <= GAP;
                  step_req <= 1'b0;
               end
            end
            GAP: begin
               state    <= IDLE;
               step_req <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               step_req <= 1'b0;
            end
         endcase
      end
   end

endmodule : game_tick_receiver

// File: tb/tb_game_tick_receiver.sv
// Directed self-checking bench for game_tick_receiver.
module tb_game_tick_receiver;

   localparam int unsigned TICK_W = 16;
   localparam int unsigned DIV_W  = 3;

   logic              clk = 1'b0;
   logic              resetn;
   logic              enable;
   logic              pulse_in;
   logic [DIV_W-1:0]  divide;
   logic              step_ack;
   logic              step_req;
   logic [TICK_W-1:0] tick_count;
   logic [1:0]        pending;
   logic              overrun;

   int n_checks = 0;
   int n_errors = 0;

   game_tick_receiver #(
      .TICK_W (TICK_W),
      .DIV_W  (DIV_W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .pulse_in   (pulse_in),
      .divide     (divide),
      .step_ack   (step_ack),
      .step_req   (step_req),
      .tick_count (tick_count),
      .pending    (pending),
      .overrun    (overrun)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n active edges; sample/drive 1 time unit after each edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic toggle();
      pulse_in = ~pulse_in;
   endtask

   int rises;
   int low_run;
   int min_low;
   logic prev_req;

   initial begin
      resetn   = 1'b0;
      enable   = 1'b1;
      pulse_in = 1'b0;
      divide   = '0;
      step_ack = 1'b0;

      // Reset with random pulse activity
      for (int i = 0; i < 10; i++) begin
         pulse_in = 1'($urandom_range(0, 1));
         cyc(1);
         check("rst_outs", {13'd0, step_req, tick_count, pending, overrun}, 32'd0);
      end
      pulse_in = 1'b0;
      cyc(1);
      resetn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         check("idle_outs", {13'd0, step_req, tick_count, pending, overrun}, 32'd0);
      end

      // Basic tick, divide=0, ack held high
      divide   = 3'd0;
      step_ack = 1'b1;
      toggle();
      cyc(1);
      cyc(1);
      check("basic_cnt_n1", 32'(tick_count), 32'd0);
      cyc(1);
      check("basic_cnt_n2", 32'(tick_count), 32'd1);
      check("basic_pend_n2", 32'(pending), 32'd1);
      check("basic_req_n2", 32'(step_req), 32'd0);
      cyc(1);
      check("basic_req_n3", 32'(step_req), 32'd1);
      check("basic_pend_n3", 32'(pending), 32'd0);
      cyc(1);
      check("basic_req_n4", 32'(step_req), 32'd0);
      cyc(5);

      // Divider by 3 over 9 ticks
      enable = 1'b0;
      cyc(1);
      check("en_clr_cnt", 32'(tick_count), 32'd0);
      enable = 1'b1;
      divide = 3'd2;
      rises = 0;
      prev_req = 1'b0;
      for (int t = 0; t < 9; t++) begin
         toggle();
         for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (step_req && !prev_req) rises++;
            prev_req = step_req;
         end
      end
      check("div_steps", 32'(rises), 32'd3);
      check("div_cnt", 32'(tick_count), 32'd9);
      check("div_pend", 32'(pending), 32'd0);

      // Queue fill and overrun
      enable = 1'b0;
      cyc(1);
      enable   = 1'b1;
      divide   = 3'd0;
      step_ack = 1'b0;
      for (int t = 0; t < 5; t++) begin
         toggle();
         cyc(10);
      end
      check("q_pend_full", 32'(pending), 32'd3);
      check("q_overrun", 32'(overrun), 32'd1);
      check("q_req_held", 32'(step_req), 32'd1);
      check("q_cnt", 32'(tick_count), 32'd5);
      step_ack = 1'b1;
      rises    = 0;
      low_run  = 0;
      min_low  = 99;
      prev_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cyc(1);
         if (step_req) begin
            if (!prev_req) begin
               rises++;
               if (low_run < min_low) min_low = low_run;
            end
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_req = step_req;
      end
      check("q_drain_reqs", 32'(rises), 32'd3);
      check("q_min_gap_ok", 32'(min_low >= 2), 32'd1);
      check("q_drain_pend", 32'(pending), 32'd0);
      check("q_overrun_sticky", 32'(overrun), 32'd1);
      step_ack = 1'b0;

      // Simultaneous generate and consume
      resetn   = 1'b0;
      pulse_in = 1'b0;
      cyc(1);
      check("rst_overrun_clr", 32'(overrun), 32'd0);
      resetn = 1'b1;
      cyc(3);
      toggle();
      cyc(4);
      check("sim_req_first", 32'(step_req), 32'd1);
      check("sim_pend0", 32'(pending), 32'd0);
      toggle();
      cyc(3);
      check("sim_pend1", 32'(pending), 32'd1);
      step_ack = 1'b1;
      toggle();
      cyc(1);
      step_ack = 1'b0;
      cyc(1);
      check("sim_gap_req", 32'(step_req), 32'd0);
      check("sim_gap_pend", 32'(pending), 32'd1);
      cyc(1);
      check("sim_req_again", 32'(step_req), 32'd1);
      check("sim_pend_same", 32'(pending), 32'd1);
      check("sim_no_overrun", 32'(overrun), 32'd0);

      // Enable drop while requesting with two queued
      toggle();
      cyc(3);
      check("drop_pend2", 32'(pending), 32'd2);
      check("drop_req_pre", 32'(step_req), 32'd1);
      check("drop_cnt_pre", 32'(tick_count), 32'd4);
      enable = 1'b0;
      cyc(1);
      check("drop_req", 32'(step_req), 32'd0);
      check("drop_pend", 32'(pending), 32'd0);
      check("drop_cnt", 32'(tick_count), 32'd0);
      check("drop_overrun", 32'(overrun), 32'd0);
      enable = 1'b1;
      cyc(10);
      check("reen_cnt", 32'(tick_count), 32'd0);
      check("reen_pend", 32'(pending), 32'd0);
      check("reen_req", 32'(step_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_game_tick_receiver

// File: doc/game_tick_receiver.md
# game_tick_receiver

Receiving end of the half-second game timebase. Consumes the toggling `pulse` square wave produced by the game counter, treats every transition (rising or falling) as one game tick, divides ticks by a programmable speed factor, and delivers each resulting game step to the game-logic FSM through a req/ack handshake. Up to three steps are buffered, and a sticky flag reports any steps that had to be dropped.

## Interface
- `TICK_W`, 16: width of the free-running tick counter.
- `DIV_W`, 3: width of the speed divider input.
- `clk`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset; clears all state.
- `enable`  in  1  synchronous run enable; low clears the divider, pending queue, FSM and `tick_count`.
- `pulse_in`  in  1  toggling timebase from the game counter; asynchronous to this block's logic and must be synchronized.
- `divide`  in  DIV_W  issue one step every `divide`+1 ticks; 0 means every tick.
- `step_ack`  in  1  game logic accepts the current step.
- `step_req`  out  1  a step is offered; held high until acknowledged.
- `tick_count`  out  TICK_W  ticks received since reset or enable low; wraps modulo 2^TICK_W.
- `pending`  out  2  steps queued but not yet offered, range 0..3.
- `overrun`  out  1  sticky; set when a step is generated while the queue is full.

## Operation
- Synchronizer chain: `s1 <= pulse_in`, `s2 <= s1`, `s3 <= s2`. The internal tick is `s2 ^ s3`.
- The chain runs regardless of `enable`, so re-enabling never produces a false tick.
- On each tick while `enable` is high:
  - `tick_count` increments.
  - Divider `div_cnt` increments, or, if `div_cnt >= divide`, resets to 0 and generates a step.
  - Using `>=` makes a decrease of `divide` mid-count fire on the next tick.
- Queue accounting, `pending`, saturating at 3:
  - A generated step adds 1.
  - The FSM leaving IDLE removes 1.
  - Generation and removal in the same cycle leave `pending` unchanged.
  - Generation at `pending`==3 with no removal sets `overrun`, and `pending` stays 3.
- FSM states:
  - IDLE: `step_req`=0. Go to REQ when `pending`>0 (consumes one step).
  - REQ: `step_req`=1. Go to GAP when `step_ack`=1 is sampled.
  - GAP: `step_req`=0. Go unconditionally to IDLE, which guarantees at least 2 low cycles between requests.
- `step_ack` sampled in IDLE or GAP is ignored.
- `enable` low:
  - FSM goes to IDLE; `step_req`, `pending`, `div_cnt` and `tick_count` are cleared on the next edge.
  - This applies even mid-handshake in REQ; the offered step is discarded.
  - `overrun` holds.
- `overrun` clears only on `resetn`.

## Timing
- Reset values:
  - `s1`, `s2`, `s3` = 0.
  - `step_req`, `tick_count`, `pending`, `overrun`, `div_cnt` = 0.
  - FSM = IDLE.
- A `pulse_in` change sampled at edge N updates `tick_count` and `pending` at edge N+2.
- `step_req` rises at edge N+3 at the earliest.
- `step_ack` high at edge M drops `step_req` after M. The next `step_req` can rise no earlier than edge M+2.
- `step_req` rises immediately after edge N+3 only if the FSM is in IDLE at that point.
- Two `pulse_in` edges closer than 2 clocks may merge; the source guarantees a 25,000,000-cycle spacing.
- Reset is asynchronous on assertion; deassertion is assumed synchronized upstream.

## Structure
- Package `game_tick_pkg`:
  - FSM state enum `{IDLE, REQ, GAP}`.
  - Constant `MAX_PENDING = 3`.
- Sub-module `pulse_edge_sync`:
  - Contains the 3-flop chain; ports `clk`, `resetn`, `d`, `edge_o`.
  - Reusable for other asynchronous game inputs.
- Top module contains the divider, queue counter, FSM and output registers.

## Test plan
- Reset then idle: hold `resetn`=0 with random `pulse_in` → all outputs 0. Release with `pulse_in` static → outputs stay 0 for 100 cycles.
- Basic tick: `divide`=0, toggle `pulse_in` once at edge 10, `step_ack` tied high:
  - `tick_count`=1 at edge 12.
  - `step_req` high for exactly one cycle starting after edge 13.
- Divider: `divide`=2, 9 toggles spaced 20 cycles apart, acking each step → exactly 3 steps, `tick_count`=9.
- Queue and overrun: `divide`=0, `step_ack`=0, 5 toggles spaced 10 cycles apart:
  - First step occupies REQ; `pending` reaches 3; `overrun`=1.
  - Then pulse `step_ack` → 3 more requests, each separated by ≥2 low cycles.
- Simultaneous: arrange a tick at the same edge the FSM leaves IDLE with `pending`=1 → `pending` stays 1 and `overrun` stays 0.
- Enable drop mid-REQ: `enable`=0 while `step_req`=1 with `pending`=2:
  - Next edge: `step_req`=0, `pending`=0, `tick_count`=0, `overrun` unchanged.
  - Re-enable with `pulse_in` static → no tick.
